// File: rtl/seq_pattern_gen.sv
// ---------------------------------------------------------------------------
// seq_pattern_gen
//
// Serial pattern transmitter. This is the driving end of the 1-bit seq link
// that the sequence-detector FSMs read. A start pulse shifts the stored
// PAT_W-bit pattern out MSB-first, one bit per clock. After the last bit the
// block drives GAP idle cycles and then pulses done for one cycle. The block
// serves as an on-chip stimulus source and as the transmit side of the
// detector link.
//
// Parameters
//   PAT_W    pattern length in bits (2..16)
//   PATTERN  pattern held in the pattern register after reset
//   GAP      idle cycles after the last bit (0..15), 0 = no gap
//
// Ports
//   i_clk        system clock, all logic on the rising edge
//   i_rst        synchronous, active-high reset
//   i_start      begin a transmission (only looked at while idle)
//   i_load_en    write i_load_pat into the pattern register (only while idle)
//   i_load_pat   new pattern value
//   i_repeat_en  (SEQ_REPEAT_EN builds only) chain another frame instead of
//                finishing
//   o_seq        serial data, registered
//   o_seq_valid  high on every cycle o_seq carries a pattern bit
//   o_busy       high from the first bit through the done cycle
//   o_done       one-cycle pulse after the gap
//
// Build option
//   SEQ_REPEAT_EN  adds i_repeat_en. When it is high on the final gap cycle
//                  (or on the final bit when GAP is 0), the pattern register
//                  is reloaded into the shifter and a new frame starts right
//                  away, with no done pulse. Without the macro the block is
//                  strictly single-shot.
// ---------------------------------------------------------------------------
module seq_pattern_gen #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter int               GAP     = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_load_en,
  input  logic [PAT_W-1:0] i_load_pat,
`ifdef SEQ_REPEAT_EN
  input  logic             i_repeat_en,
`endif
  output logic             o_seq,
  output logic             o_seq_valid,
  output logic             o_busy,
  output logic             o_done
);

  localparam int CNT_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(PAT_W - 1);
  localparam logic [3:0] LAST_GAP = 4'((GAP > 0) ? (GAP - 1) : 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SEND = 2'b01,
    ST_GAP  = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  state_t             r_state;
  logic [PAT_W-1:0]   r_patReg;
  logic [PAT_W-1:0]   r_shiftReg;
  logic [CNT_W-1:0]   r_bitCnt;
  logic [3:0]         r_gapCnt;
  logic               r_seqValid;
  logic               r_busy;
  logic               r_done;

  state_t             w_nextState;
  logic [PAT_W-1:0]   w_nextPat;
  logic [PAT_W-1:0]   w_nextShift;
  logic [CNT_W-1:0]   w_nextBitCnt;
  logic [3:0]         w_nextGapCnt;
  logic               w_nextValid;
  logic               w_nextBusy;
  logic               w_nextDone;
  logic [PAT_W-1:0]   w_framePat;
  logic               w_repeat;

  // The repeat request is tied low in the single-shot build so the FSM below
  // is identical in both configurations.
`ifdef SEQ_REPEAT_EN
  assign w_repeat = i_repeat_en;
`else
  assign w_repeat = 1'b0;
`endif

  // The serial bit is simply the MSB of the shifter. Shifting left once more
  // after the last bit leaves the shifter all zero, so o_seq reads 0 during
  // the gap, done and idle without any extra gating.
  assign o_seq       = r_shiftReg[PAT_W-1];
  assign o_seq_valid = r_seqValid;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

  // Next-state and next-output logic. Every output is computed here one cycle
  // ahead and captured by the register block, so all outputs come straight
  // from flops. A start that coincides with a load transmits the freshly
  // loaded value, which is why the frame source is muxed ahead of the shifter.
  always_comb begin
    w_nextState  = r_state;
    w_nextPat    = r_patReg;
    w_nextShift  = r_shiftReg;
    w_nextBitCnt = r_bitCnt;
    w_nextGapCnt = r_gapCnt;
    w_nextValid  = 1'b0;
    w_nextBusy   = 1'b0;
    w_nextDone   = 1'b0;
    w_framePat   = i_load_en ? i_load_pat : r_patReg;

    case (r_state)
      ST_IDLE: begin
        if (i_load_en) begin
          w_nextPat = i_load_pat;
        end
        if (i_start) begin
          w_nextState  = ST_SEND;
          w_nextShift  = w_framePat;
          w_nextBitCnt = '0;
          w_nextValid  = 1'b1;
          w_nextBusy   = 1'b1;
        end
      end

      ST_SEND: begin
        w_nextBusy  = 1'b1;
        w_nextShift = r_shiftReg << 1;
        if (r_bitCnt == LAST_BIT) begin
          w_nextBitCnt = '0;
          if (GAP == 0) begin
            if (w_repeat) begin
              w_nextShift = r_patReg;
              w_nextValid = 1'b1;
            end else begin
              w_nextState = ST_DONE;
              w_nextDone  = 1'b1;
            end
          end else begin
            w_nextState  = ST_GAP;
            w_nextGapCnt = '0;
          end
        end else begin
          w_nextBitCnt = r_bitCnt + 1'b1;
          w_nextValid  = 1'b1;
        end
      end

      ST_GAP: begin
        w_nextBusy = 1'b1;
        if (r_gapCnt == LAST_GAP) begin
          w_nextGapCnt = '0;
          if (w_repeat) begin
            w_nextState  = ST_SEND;
            w_nextShift  = r_patReg;
            w_nextBitCnt = '0;
            w_nextValid  = 1'b1;
          end else begin
            w_nextState = ST_DONE;
            w_nextDone  = 1'b1;
          end
        end else begin
          w_nextGapCnt = r_gapCnt + 1'b1;
        end
      end

      ST_DONE: begin
        w_nextState = ST_IDLE;
      end

      default: begin
        w_nextState = ST_IDLE;
        w_nextShift = '0;
      end
    endcase
  end

  // State and output registers. Reset drops any frame in flight, clears every
  // output and restores the power-up pattern.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_patReg   <= PATTERN;
      r_shiftReg <= '0;
      r_bitCnt   <= '0;
      r_gapCnt   <= '0;
      r_seqValid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_patReg   <= w_nextPat;
      r_shiftReg <= w_nextShift;
      r_bitCnt   <= w_nextBitCnt;
      r_gapCnt   <= w_nextGapCnt;
      r_seqValid <= w_nextValid;
      r_busy     <= w_nextBusy;
      r_done     <= w_nextDone;
    end
  end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_seq_pattern_gen
//
// Self-checking bench for seq_pattern_gen with default parameters. A queue
// based reference model predicts {seq, seq_valid, busy, done} for every cycle
// from the frame rules: a frame is PAT_W data beats followed by GAP idle
// beats, then a done beat unless a repeat is requested. A compare process
// checks the DUT against it on every falling edge. Directed scenarios also
// check hand-computed literal values. With SEQ_REPEAT_EN defined the repeat
// port is connected and exercised.
// ---------------------------------------------------------------------------
module tb_seq_pattern_gen;

  localparam int         PAT_W   = 4;
  localparam logic [3:0] PATTERN = 4'b1011;
  localparam int         GAP     = 2;

  logic       clk;
  logic       rst;
  logic       start;
  logic       loadEn;
  logic [3:0] loadPat;
  logic       repeatEn;
  logic       seq;
  logic       seqValid;
  logic       busy;
  logic       done;

  int vectors;
  int miscompares;
  bit chkEn;

  // Model state. Each beat is {seq, seq_valid, busy, done}.
  logic [3:0] cur;
  logic [3:0] beatQ[$];
  logic [3:0] mPat;
  logic [3:0] framePat;

  logic [3:0] expDefault [8];
  logic [3:0] expLoaded  [8];
  int         doneCount;

  seq_pattern_gen #(
    .PAT_W   (PAT_W),
    .PATTERN (PATTERN),
    .GAP     (GAP)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_load_en   (loadEn),
    .i_load_pat  (loadPat),
`ifdef SEQ_REPEAT_EN
    .i_repeat_en (repeatEn),
`endif
    .o_seq       (seq),
    .o_seq_valid (seqValid),
    .o_busy      (busy),
    .o_done      (done)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Queue up one complete frame body: data beats MSB first, then gap beats.
  task automatic buildFrame(input logic [3:0] p);
    for (int i = PAT_W - 1; i >= 0; i--) begin
      beatQ.push_back({p[i], 1'b1, 1'b1, 1'b0});
    end
    for (int g = 0; g < GAP; g++) begin
      beatQ.push_back(4'b0010);
    end
  endtask

  // Reference model, advanced on every rising edge with the inputs the DUT
  // sees on that edge. Idle means the current beat is not busy. When the
  // frame body runs out the generator either restarts (repeat) or emits the
  // done beat, after which it returns to idle.
  always @(posedge clk) begin
    if (rst) begin
      beatQ.delete();
      mPat = PATTERN;
      cur  = 4'b0000;
    end else if (cur[1] == 1'b0) begin
      framePat = loadEn ? loadPat : mPat;
      if (loadEn) mPat = loadPat;
      if (start) begin
        buildFrame(framePat);
        cur = beatQ.pop_front();
      end else begin
        cur = 4'b0000;
      end
    end else if (cur[0]) begin
      cur = 4'b0000;
    end else if (beatQ.size() != 0) begin
      cur = beatQ.pop_front();
    end else if (repeatEn) begin
      buildFrame(mPat);
      cur = beatQ.pop_front();
    end else begin
      cur = 4'b0011;
    end
  end

  // Per-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (chkEn) begin
      vectors++;
      if ({seq, seqValid, busy, done} !== cur) begin
        miscompares++;
        $display("[TB] FAIL model t=%0t got seq/valid/busy/done=%b expected %b",
                 $time, {seq, seqValid, busy, done}, cur);
      end
    end
  end

  // Drive one cycle's worth of inputs shortly after a rising edge.
  task automatic applyStimulus(input logic s, input logic l, input logic [3:0] p,
                               input logic r, input logic rep);
    @(posedge clk);
    #2;
    start    = s;
    loadEn   = l;
    loadPat  = p;
    rst      = r;
    repeatEn = rep;
  endtask

  // Literal check of the outputs in the next low clock phase.
  task automatic checkOutput(input string name, input logic [3:0] expVal);
    @(negedge clk);
    #1;
    vectors++;
    if ({seq, seqValid, busy, done} !== expVal) begin
      miscompares++;
      $display("[TB] FAIL %s got seq/valid/busy/done=%b expected %b",
               name, {seq, seqValid, busy, done}, expVal);
    end
  endtask

  task automatic checkCount(input string name, input int got, input int expVal);
    vectors++;
    if (got != expVal) begin
      miscompares++;
      $display("[TB] FAIL %s got %0d expected %0d", name, got, expVal);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    chkEn       = 1'b1;
    cur         = 4'b0000;
    mPat        = PATTERN;
    rst         = 1'b1;
    start       = 1'b0;
    loadEn      = 1'b0;
    loadPat     = 4'b0000;
    repeatEn    = 1'b0;

    expDefault = '{4'b1110, 4'b0110, 4'b1110, 4'b1110,
                   4'b0010, 4'b0010, 4'b0011, 4'b0000};
    expLoaded  = '{4'b0110, 4'b1110, 4'b1110, 4'b0110,
                   4'b0010, 4'b0010, 4'b0011, 4'b0000};

    // Two reset cycles, then everything must be quiet.
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    checkOutput("reset", 4'b0000);

    // Default pattern: 1,0,1,1 then two gap cycles, done, idle.
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
      checkOutput($sformatf("default_frame_%0d", k), expDefault[k]);
    end

    // Load and start together: the new value goes out and is kept.
    applyStimulus(1'b1, 1'b1, 4'b0110, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
      checkOutput($sformatf("load_start_%0d", k), expLoaded[k]);
    end
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
      checkOutput($sformatf("resend_%0d", k), expLoaded[k]);
    end

    // Start and load while sending are ignored: exactly one done pulse.
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 4'b1111, 1'b0, 1'b0);
    doneCount = 0;
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
      @(negedge clk);
      if (done) doneCount++;
    end
    checkCount("ignored_start_done_pulses", doneCount, 1);

    // Reset during the third bit drops the frame and restores 1011.
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    checkOutput("mid_frame_reset", 4'b0000);
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
      checkOutput($sformatf("after_reset_%0d", k), expDefault[k]);
    end

`ifdef SEQ_REPEAT_EN
    // Three chained frames, repeat dropped during the third gap.
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b0, 1'b1);
    doneCount = 0;
    for (int k = 0; k < 22; k++) begin
      applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, (k < 16) ? 1'b1 : 1'b0);
      @(negedge clk);
      if (done) doneCount++;
      if (k == 6) begin
        vectors++;
        if ({seq, seqValid, busy} !== 3'b111) begin
          miscompares++;
          $display("[TB] FAIL repeat_first_bit got %b expected 111",
                   {seq, seqValid, busy});
        end
      end
    end
    checkCount("repeat_done_pulses", doneCount, 1);
`endif

    // Randomized traffic against the model.
    for (int k = 0; k < 600; k++) begin
      applyStimulus(($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
                    4'($urandom_range(0, 15)), ($urandom_range(0, 60) == 0),
`ifdef SEQ_REPEAT_EN
                    ($urandom_range(0, 2) == 0)
`else
                    1'b0
`endif
                    );
    end
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    for (int k = 0; k < 30; k++) begin
      applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    end
    checkOutput("final_idle", 4'b0000);

    @(posedge clk);
    chkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
